alu_issue: RTL and testbench
============================

# alu_issue

Sequential issue/writeback controller that drives the combinational `arithmetic` unit from the producer side. It accepts one raw RV32I OP or OP-IMM instruction word through a valid/ready handshake and decodes it into the ALU's `lhs`/`rhs`/`operation`/`metadata` inputs. It reads operands from its own 32-entry register file, collects `result`/`valid`, and writes back `rd`. It is the execute-stage front end of the multi-cycle core; the ALU stays purely combinational.

## Interface
- DATA_WIDTH, 32, register and operand width; shift amount is the low $clog2(DATA_WIDTH) bits.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- instr_valid  input  1  instruction word offered.
- instr_ready  output  1  high only in IDLE.
- instr  input  32  RV32I instruction word.
- alu_lhs  output  DATA_WIDTH  drives ALU `lhs`; registered.
- alu_rhs  output  DATA_WIDTH  drives ALU `rhs`; registered.
- alu_operation  output  3  drives ALU `operation` (funct3); registered.
- alu_metadata  output  7  drives ALU `metadata`; registered.
- alu_result  input  DATA_WIDTH  from ALU `result`.
- alu_valid  input  1  from ALU `valid`.
- done_valid  output  1  one-cycle completion pulse.
- done_rd  output  5  destination index of the completed instruction.
- done_value  output  DATA_WIDTH  captured ALU result; 0 when illegal.
- done_illegal  output  1  instruction rejected; no writeback.
- dbg_addr  input  5  debug register read index.
- dbg_data  output  DATA_WIDTH  combinational read of regfile[dbg_addr]; x0 reads 0.

## Operation
- Register file: 32 × DATA_WIDTH. x0 is hardwired to 0 and writes to it are discarded.
- FSM has four states, IDLE → DECODE → EXECUTE → WRITEBACK → IDLE, with no other transitions.
- IDLE: `instr_ready=1`. On `instr_valid && instr_ready`, latch `instr` and go to DECODE.
- DECODE:
  - Read rs1 and rs2, then register the ALU drive outputs.
  - `alu_lhs` = reg[rs1].
  - `alu_operation` = instr[14:12].
  - Opcode 0x33 (OP): `alu_rhs` = reg[rs2]; `alu_metadata` = instr[31:25].
  - Opcode 0x13 (OP-IMM), funct3 ∈ {1,5}: `alu_metadata` = instr[31:25]; `alu_rhs` = zero-extended instr[24:20].
  - Opcode 0x13 (OP-IMM), other funct3: `alu_metadata` = 0; `alu_rhs` = sign-extended instr[31:20].
  - Shift masking: for funct3 ∈ {1,5} in both formats, `alu_rhs` is masked to its low $clog2(DATA_WIDTH) bits.
  - Any other opcode sets the internal illegal flag and holds the ALU outputs.
- EXECUTE: capture `alu_result` and `alu_valid`. `alu_valid=0` sets the illegal flag.
- WRITEBACK:
  - Pulse `done_valid` with `done_rd`, `done_value` and `done_illegal`.
  - If not illegal and rd≠0, write reg[rd] at the closing edge of this cycle.
- The illegal flag clears on the next accept.
- Reset:
  - State returns to IDLE and all registers clear to 0.
  - `alu_*` outputs = 0, `done_*` = 0, `instr_ready=1` from the first cycle after `rst` deasserts.

## Timing
- Accept edge N. DECODE occupies cycle N+1, EXECUTE N+2, WRITEBACK N+3 (`done_valid` high for exactly that cycle). Back in IDLE at N+4.
- Throughput is one instruction per 4 cycles. `instr_valid` during non-IDLE cycles is ignored and nothing is dropped from the producer's view: it must hold until ready.
- The write in WRITEBACK lands before the next DECODE, so back-to-back dependent instructions need no forwarding.
- `dbg_data` reflects a write from the cycle after the write edge.
- Reset mid-operation (any non-IDLE state): abort with no register write and no `done_valid`, then re-enter IDLE.

## Test plan
- **Reset.** `rst=0` for 2 cycles, then release → `instr_ready=1`, all `done_*`/`alu_*` = 0, `dbg_data=0` for every `dbg_addr`.
- **ADDI x1,x0,-5 (0xFFB00093), then SRAI x2,x1,1 (0x4010D113).**
  - ADDI: `done_valid` at N+3, rd=1, value 0xFFFFFFFB.
  - SRAI: `alu_rhs=1`, `alu_metadata=0x20`, value 0xFFFFFFFD.
- **SUB x3,x1,x2 (0x402081B3)** → `alu_metadata=0x20`, value 0xFFFFFFFE, reg x3 = 0xFFFFFFFE.
- **Shift masking.** ADDI x4,x0,33 (0x02100213), then SLL x5,x4,x4 (0x004212B3) → `alu_rhs=1`, x5 = 0x42.
- **Illegal and x0 writes.**
  - MUL x6,x1,x2 (0x02208333): `alu_valid=0` → `done_illegal=1`, x6 stays 0.
  - LUI (opcode 0x37): `done_illegal=1`.
  - ADDI x0,x0,7: done rd=0, x0 still reads 0.
- **Busy and reset mid-op.**
  - Hold `instr_valid` across a busy instruction → the second instruction is accepted only at N+4.
  - Assert `rst` in EXECUTE of ADDI x7,x0,1 → no `done_valid`, x7=0, ready after release.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/writeback controller for the combinational arithmetic unit: decodes RV32I
// OP/OP-IMM words, drives the ALU from a private register file and writes back rd.
module alu_issue #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic [DATA_WIDTH-1:0] alu_lhs,
  output logic [DATA_WIDTH-1:0] alu_rhs,
  output logic [2:0]            alu_operation,
  output logic [6:0]            alu_metadata,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_valid,
  output logic                  done_valid,
  output logic [4:0]            done_rd,
  output logic [DATA_WIDTH-1:0] done_value,
  output logic                  done_illegal,
  input  logic [4:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SHMASK = {{(DATA_WIDTH-SHW){1'b0}}, {SHW{1'b1}}};
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

  state_t                state;
  logic [31:0]           instr_q;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] regs [32];

  logic [6:0]            opcode;
  logic [4:0]            rd, rs1, rs2;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  is_shift;
  logic                  dec_legal;
  logic [DATA_WIDTH-1:0] dec_rhs;
  logic [6:0]            dec_meta;
  logic                  exec_bad;

  assign opcode   = instr_q[6:0];
  assign rd       = instr_q[11:7];
  assign funct3   = instr_q[14:12];
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign funct7   = instr_q[31:25];
  assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);
  assign exec_bad = illegal || !alu_valid;

  always_comb begin
    dec_legal = 1'b1;
    dec_rhs   = '0;
    dec_meta  = '0;
    if (opcode == OPC_OP) begin
      dec_rhs  = regs[rs2];
      dec_meta = funct7;
    end else if (opcode == OPC_OP_IMM) begin
      if (is_shift) begin
        dec_rhs  = {{(DATA_WIDTH-5){1'b0}}, rs2};
        dec_meta = funct7;
      end else begin
        dec_rhs  = {{(DATA_WIDTH-12){instr_q[31]}}, instr_q[31:20]};
      end
    end else begin
      dec_legal = 1'b0;
    end
    // Shift amounts only ever use the low log2(width) bits, in both formats.
    if (is_shift) dec_rhs = dec_rhs & SHMASK;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      instr_q       <= '0;
      illegal       <= 1'b0;
      alu_lhs       <= '0;
      alu_rhs       <= '0;
      alu_operation <= '0;
      alu_metadata  <= '0;
      done_valid    <= 1'b0;
      done_rd       <= '0;
      done_value    <= '0;
      done_illegal  <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            illegal <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            alu_lhs       <= regs[rs1];
            alu_rhs       <= dec_rhs;
            alu_operation <= funct3;
            alu_metadata  <= dec_meta;
          end else begin
            illegal <= 1'b1;
          end
          state <= EXECUTE;
        end
        EXECUTE: begin
          illegal      <= exec_bad;
          done_valid   <= 1'b1;
          done_rd      <= rd;
          done_illegal <= exec_bad;
          done_value   <= exec_bad ? '0 : alu_result;
          state        <= WRITEBACK;
        end
        WRITEBACK: begin
          done_valid <= 1'b0;
          if (!illegal && done_rd != 5'd0) regs[done_rd] <= done_value;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state == IDLE);
  assign dbg_data    = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural stand-in for the arithmetic unit.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_lhs, alu_rhs, alu_result;
  logic [2:0]  alu_operation;
  logic [6:0]  alu_metadata;
  logic        alu_valid;
  logic        done_valid;
  logic [4:0]  done_rd;
  logic [31:0] done_value;
  logic        done_illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_operation(alu_operation),
    .alu_metadata(alu_metadata), .alu_result(alu_result), .alu_valid(alu_valid),
    .done_valid(done_valid), .done_rd(done_rd), .done_value(done_value),
    .done_illegal(done_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Arithmetic unit: base ops with metadata 0, SUB/SRA with 0x20, anything else invalid.
  always_comb begin
    alu_result = '0;
    alu_valid  = 1'b1;
    case (alu_metadata)
      7'h00: case (alu_operation)
        3'd0: alu_result = alu_lhs + alu_rhs;
        3'd1: alu_result = alu_lhs << alu_rhs[4:0];
        3'd2: alu_result = {31'd0, $signed(alu_lhs) < $signed(alu_rhs)};
        3'd3: alu_result = {31'd0, alu_lhs < alu_rhs};
        3'd4: alu_result = alu_lhs ^ alu_rhs;
        3'd5: alu_result = alu_lhs >> alu_rhs[4:0];
        3'd6: alu_result = alu_lhs | alu_rhs;
        default: alu_result = alu_lhs & alu_rhs;
      endcase
      7'h20: begin
        if (alu_operation == 3'd0)      alu_result = alu_lhs - alu_rhs;
        else if (alu_operation == 3'd5) alu_result = $signed(alu_lhs) >>> alu_rhs[4:0];
        else                            alu_valid  = 1'b0;
      end
      default: alu_valid = 1'b0;
    endcase
  end

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        illegal;
    logic        chk_alu;
    logic [31:0] rhs;
    logic [6:0]  meta;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] exp_regs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic issue(input vec_t v, input int idx);
    logic [3:0]  dv;
    logic [31:0] rhs_s, val_s;
    logic [6:0]  meta_s;
    logic [4:0]  rd_s;
    logic        ill_s, rdy_s;
    wait_ready($sformatf("ready_v%0d", idx));
    instr       = v.instr;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk); dv[0] = done_valid;
    @(negedge clk); dv[1] = done_valid; rhs_s = alu_rhs; meta_s = alu_metadata;
    @(negedge clk); dv[2] = done_valid; rd_s = done_rd; val_s = done_value; ill_s = done_illegal;
    @(negedge clk); dv[3] = done_valid; rdy_s = instr_ready;
    check($sformatf("done_timing_v%0d", idx), {28'd0, dv}, 32'h4);
    check($sformatf("ready_after_v%0d", idx), {31'd0, rdy_s}, 32'd1);
    check($sformatf("done_rd_v%0d", idx), {27'd0, rd_s}, {27'd0, v.rd});
    check($sformatf("done_value_v%0d", idx), val_s, v.value);
    check($sformatf("done_illegal_v%0d", idx), {31'd0, ill_s}, {31'd0, v.illegal});
    if (v.chk_alu) begin
      check($sformatf("alu_rhs_v%0d", idx), rhs_s, v.rhs);
      check($sformatf("alu_meta_v%0d", idx), {25'd0, meta_s}, {25'd0, v.meta});
    end
  endtask

  initial begin
    int          nerr;
    logic [3:0]  rdy;
    logic [31:0] a_val;
    logic        saw_done;

    vecs[0]  = '{32'hFFB00093, 5'd1,  32'hFFFFFFFB, 1'b0, 1'b1, 32'hFFFFFFFB, 7'h00};
    vecs[1]  = '{32'h4010D113, 5'd2,  32'hFFFFFFFD, 1'b0, 1'b1, 32'h00000001, 7'h20};
    vecs[2]  = '{32'h402081B3, 5'd3,  32'hFFFFFFFE, 1'b0, 1'b1, 32'hFFFFFFFD, 7'h20};
    vecs[3]  = '{32'h02100213, 5'd4,  32'h00000021, 1'b0, 1'b1, 32'h00000021, 7'h00};
    vecs[4]  = '{32'h004212B3, 5'd5,  32'h00000042, 1'b0, 1'b1, 32'h00000001, 7'h00};
    vecs[5]  = '{32'h02208333, 5'd6,  32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFD, 7'h01};
    vecs[6]  = '{32'h12345437, 5'd8,  32'h00000000, 1'b1, 1'b0, 32'h00000000, 7'h00};
    vecs[7]  = '{32'h00700013, 5'd0,  32'h00000007, 1'b0, 1'b1, 32'h00000007, 7'h00};
    vecs[8]  = '{32'h0F00C493, 5'd9,  32'hFFFFFF0B, 1'b0, 1'b1, 32'h000000F0, 7'h00};
    vecs[9]  = '{32'h0020A533, 5'd10, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFD, 7'h00};
    vecs[10] = '{32'h0040D593, 5'd11, 32'h0FFFFFFF, 1'b0, 1'b1, 32'h00000004, 7'h00};
    exp_regs = '{32'h0, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h21, 32'h42,
                 32'h0, 32'h0, 32'h0, 32'hFFFFFF0B, 32'h1, 32'h0FFFFFFF};

    rst = 1'b0; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, instr_ready}, 32'd1);
    check("reset_done", {done_valid, done_illegal, done_rd, done_value[24:0]} | {7'd0, done_value[31:7]},
          32'd0);
    check("reset_alu", alu_lhs | alu_rhs | {22'd0, alu_operation, alu_metadata}, 32'd0);
    nerr = 0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 if (dbg_data !== 32'd0) nerr++;
    end
    check("reset_regfile", 32'(nerr), 32'd0);

    for (int i = 0; i < 11; i++) issue(vecs[i], i);

    for (int i = 0; i < 12; i++) begin
      dbg_addr = 5'(i);
      #1 check($sformatf("reg_x%0d", i), dbg_data, exp_regs[i]);
    end

    // Busy: second word held valid from the cycle after the first accept.
    wait_ready("ready_busy");
    instr = 32'h06400613; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = 32'h00160693;
    a_val = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rdy[k] = instr_ready;
      if (k == 2) a_val = done_valid ? done_value : 32'hDEAD;
    end
    check("busy_ready_pattern", {28'd0, rdy}, 32'h8);
    check("busy_first_value", a_val, 32'h64);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("busy_second_done", {31'd0, done_valid}, 32'd1);
    check("busy_second_rd", {27'd0, done_rd}, 32'd13);
    check("busy_second_value", done_value, 32'h65);
    @(negedge clk); @(negedge clk);
    dbg_addr = 5'd13;
    #1 check("reg_x13", dbg_data, 32'h65);

    // Reset asserted during EXECUTE aborts the instruction.
    wait_ready("ready_abort");
    instr = 32'h00100393; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      saw_done |= done_valid;
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      saw_done |= done_valid;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_ready", {31'd0, instr_ready}, 32'd1);
    dbg_addr = 5'd7;
    #1 check("abort_x7", dbg_data, 32'd0);
    dbg_addr = 5'd1;
    #1 check("abort_x1_cleared", dbg_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
